// File: rtl/execute_muldiv_if.sv
// execute_muldiv_if: request/response bundle between Execute and the mul/div engine
// Signals: start/op/a/b/flush driven by Execute (master);
//          busy/done/hi/lo/div0 driven by the engine (slave).
interface execute_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div0;
    modport master (output start, op, a, b, flush, input busy, done, hi, lo, div0);
    modport slave (input start, op, a, b, flush, output busy, done, hi, lo, div0);
endinterface

// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit: iterative MULT/MULTU/DIV/DIVU/MUL engine producing HI/LO for Execute
// Ports: clk, rst (asynchronous, active high);
//        mdu (execute_muldiv_if.slave): start, op, a, b, flush in; busy, done, hi, lo, div0 out.
// Optional feature macro MULDIV_DIV0_FAST_EN: divide by zero finishes in one cycle and pulses div0.
module execute_muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 3
) (
    input logic             clk,
    input logic             rst,
    execute_muldiv_if.slave mdu
);
    localparam int MAXC = WIDTH > MUL_LATENCY ? WIDTH : MUL_LATENCY;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   ma_q, mb_q, rem_q, quo_q, hi_q, lo_q;
    logic               neg_q, an_q, div_q, fast_q, busy_q, done_q;
    logic               is_div, sgn, a_neg, b_neg, fast, ge;
    logic [WIDTH-1:0]   ma, mb, rem_d, quo_d, q_fix, r_fix, res_hi, res_lo;
    logic [WIDTH:0]     sh;
    logic [2*WIDTH-1:0] prod, sprod;

    // Operand decode: signed ops work on magnitudes, INT_MIN maps to 2^(WIDTH-1).
    always_comb begin
        is_div = mdu.op == 3'd2 || mdu.op == 3'd3;
        sgn    = mdu.op == 3'd0 || mdu.op == 3'd2 || mdu.op == 3'd4;
        a_neg  = sgn && mdu.a[WIDTH-1];
        b_neg  = sgn && mdu.b[WIDTH-1];
        ma     = a_neg ? -mdu.a : mdu.a;
        mb     = b_neg ? -mdu.b : mdu.b;
`ifdef MULDIV_DIV0_FAST_EN
        fast   = is_div && mdu.b == '0;
`else
        fast   = 1'b0;
`endif
    end

    // Restoring division step; quo_q doubles as the dividend shift register.
    always_comb begin
        sh     = {rem_q, quo_q[WIDTH-1]};
        ge     = sh >= {1'b0, mb_q};
        rem_d  = ge ? sh[WIDTH-1:0] - mb_q : sh[WIDTH-1:0];
        quo_d  = {quo_q[WIDTH-2:0], ge};
        prod   = {{WIDTH{1'b0}}, ma_q} * {{WIDTH{1'b0}}, mb_q};
        sprod  = neg_q ? -prod : prod;
        q_fix  = neg_q ? -quo_q : quo_q;
        r_fix  = an_q ? -rem_q : rem_q;
        res_hi = div_q ? r_fix : sprod[2*WIDTH-1:WIDTH];
        res_lo = div_q ? q_fix : sprod[WIDTH-1:0];
    end

    // The cycle with cnt_q == 0 in MUL/DIV is the done cycle; flush there is too late.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (mdu.start && !mdu.flush) begin
                state_d = is_div ? DIV : MUL;
                cnt_d   = is_div ? (fast ? '0 : CW'(WIDTH)) : CW'(MUL_LATENCY - 1);
            end
        end else if (cnt_q == '0 || mdu.flush) begin
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            an_q    <= 1'b0;
            div_q   <= 1'b0;
            fast_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= state_d != IDLE;
            done_q  <= state_d != IDLE && cnt_d == '0;
            if (state_q == IDLE && state_d != IDLE) begin
                ma_q   <= ma;
                mb_q   <= mb;
                div_q  <= is_div;
                fast_q <= fast;
                an_q   <= a_neg;
                // Fast divide-by-zero: preload the final remainder/quotient, no quotient negation.
                neg_q  <= !fast && (a_neg ^ b_neg);
                rem_q  <= fast ? ma : '0;
                quo_q  <= fast ? '1 : ma;
            end else if (state_q == DIV && cnt_q != '0) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
            end
            if (done_q) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    // The result is visible during the done cycle itself, then held in hi_q/lo_q.
    assign mdu.busy = busy_q;
    assign mdu.done = done_q;
    assign mdu.hi   = done_q ? res_hi : hi_q;
    assign mdu.lo   = done_q ? res_lo : lo_q;
    assign mdu.div0 = done_q && fast_q;
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb_execute_muldiv_unit: scoreboard bench for execute_muldiv_unit (WIDTH=32, MUL_LATENCY=3)
module tb_execute_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

`ifdef MULDIV_DIV0_FAST_EN
    localparam int D0_LAT = 1;
    localparam bit FAST   = 1'b1;
`else
    localparam int D0_LAT = 33;
    localparam bit FAST   = 1'b0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        d0;
        int          at;
    } exp_t;

    exp_t sb[$];

    execute_muldiv_if #(.WIDTH(32)) mdu();

    execute_muldiv_unit #(.WIDTH(32), .MUL_LATENCY(3)) dut (
        .clk(clk),
        .rst(rst),
        .mdu(mdu)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdu.start = 1'b1;
        mdu.op    = op;
        mdu.a     = a;
        mdu.b     = b;
    endtask

    task automatic expect_res(input logic [31:0] ehi, input logic [31:0] elo, input logic d0, input int lat);
        sb.push_back('{ehi, elo, d0, cyc + lat});
        last_hi = ehi;
        last_lo = elo;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!mdu.busy) return;
        end
        total++;
        bad++;
        $display("FAIL idle_timeout: busy still 1 after 60 cycles, required 0");
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic d0, input int lat);
        drive(op, a, b);
        expect_res(ehi, elo, d0, lat);
        step;
        mdu.start = 1'b0;
        wait_idle;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && mdu.done) begin
            exp_t e;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.at));
                chk("hi", mdu.hi, e.hi);
                chk("lo", mdu.lo, e.lo);
                chk("div0", {31'b0, mdu.div0}, {31'b0, e.d0});
            end
        end
    end

    initial begin
        mdu.start = 1'b0;
        mdu.flush = 1'b0;
        mdu.op    = '0;
        mdu.a     = '0;
        mdu.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, mdu.busy}, 32'd0);
        chk("rst_done", {31'b0, mdu.done}, 32'd0);
        chk("rst_hi", mdu.hi, 32'd0);
        chk("rst_lo", mdu.lo, 32'd0);
        chk("rst_div0", {31'b0, mdu.div0}, 32'd0);
        rst = 1'b0;
        step;
        issue(3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 3);
        step;
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 3);
        step;
        issue(3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 3);
        step;
        issue(3'd7, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 3);
        step;
        issue(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 3);
        step;
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        step;
        issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
        step;
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
        step;
        issue(3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, FAST, D0_LAT);
        step;
        issue(3'd2, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, FAST ? 32'hFFFFFFFF : 32'h00000001, FAST, D0_LAT);
        step;
        step;
        chk("hold_hi", mdu.hi, last_hi);
        chk("hold_lo", mdu.lo, last_lo);
        // Flush mid-divide at T+10, restart at T+11.
        step;
        drive(3'd2, 32'd100, 32'd7);
        step;
        mdu.start = 1'b0;
        repeat (9) step;
        mdu.flush = 1'b1;
        step;
        mdu.flush = 1'b0;
        chk("flush_busy", {31'b0, mdu.busy}, 32'd0);
        chk("flush_hi", mdu.hi, last_hi);
        chk("flush_lo", mdu.lo, last_lo);
        issue(3'd3, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, 33);
        // start together with flush in IDLE is dropped.
        step;
        drive(3'd1, 32'd3, 32'd4);
        mdu.flush = 1'b1;
        step;
        mdu.start = 1'b0;
        mdu.flush = 1'b0;
        chk("startflush_busy", {31'b0, mdu.busy}, 32'd0);
        repeat (5) step;
        // start while busy is ignored.
        drive(3'd2, 32'hFFFFFFF9, 32'd2);
        expect_res(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        step;
        mdu.start = 1'b0;
        repeat (4) step;
        drive(3'd1, 32'd2, 32'd3);
        step;
        mdu.start = 1'b0;
        wait_idle;
        repeat (6) step;
        chk("ignored_busy", {31'b0, mdu.busy}, 32'd0);
        // Asynchronous reset mid-divide.
        drive(3'd3, 32'd100, 32'd7);
        step;
        mdu.start = 1'b0;
        repeat (4) step;
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, mdu.busy}, 32'd0);
        chk("arst_done", {31'b0, mdu.done}, 32'd0);
        chk("arst_hi", mdu.hi, 32'd0);
        chk("arst_lo", mdu.lo, 32'd0);
        step;
        rst = 1'b0;
        repeat (40) step;
        chk("post_rst_busy", {31'b0, mdu.busy}, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
